qar_can_rx_mailbox: RTL and testbench

Parametrised CAN receive mailbox between the QAR-Core CAN controller's frame deserialiser and the CAN MMIO register block. It replaces the single-frame RX holding register with a DEPTH-frame FIFO. Frames are qualified by NUM_FILTERS programmable ID/mask acceptance filters, overflow is counted, and an optional capture timestamp can be compiled in. Firmware drains frames through a show-ahead head entry plus a pop strobe.

---
 rtl/qar_can_rx_mailbox_if.sv | 30 +++
 rtl/qar_can_rx_mailbox.sv | 166 ++++++++++++++++
 tb/tb_qar_can_rx_mailbox.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/qar_can_rx_mailbox_if.sv
// Frame-in / head-out bundle between the CAN deserialiser, the RX mailbox
// and the MMIO register block that drains it.
interface qar_can_rx_mailbox_if #(
  parameter int ID_WIDTH    = 11,
  parameter int NUM_FILTERS = 2
);
  localparam int HIT_W = $clog2(NUM_FILTERS);

  logic                frm_valid;
  logic [ID_WIDTH-1:0] frm_id;
  logic [3:0]          frm_dlc;
  logic [63:0]         frm_data;
  logic                rd_pop;
  logic                rd_valid;
  logic [ID_WIDTH-1:0] rd_id;
  logic [3:0]          rd_dlc;
  logic [63:0]         rd_data;
  logic [HIT_W-1:0]    rd_hit;
  logic [15:0]         rd_tstamp;

  modport master (
    output frm_valid, frm_id, frm_dlc, frm_data, rd_pop,
    input  rd_valid, rd_id, rd_dlc, rd_data, rd_hit, rd_tstamp
  );

  modport slave (
    input  frm_valid, frm_id, frm_dlc, frm_data, rd_pop,
    output rd_valid, rd_id, rd_dlc, rd_data, rd_hit, rd_tstamp
  );
endinterface

// File: rtl/qar_can_rx_mailbox.sv
// CAN RX mailbox: ID/mask acceptance filters feeding a DEPTH-frame show-ahead FIFO
// with saturating overflow counter. Define QAR_CAN_RX_TIMESTAMP_EN for capture timestamps.
module qar_can_rx_mailbox #(
  parameter int DEPTH       = 4,
  parameter int NUM_FILTERS = 2,
  parameter int ID_WIDTH    = 11
) (
  input  logic                           clk,
  input  logic                           rst_n,
  qar_can_rx_mailbox_if.slave            bus,
  input  logic                           flt_we,
  input  logic [$clog2(NUM_FILTERS)-1:0] flt_idx,
  input  logic                           flt_en,
  input  logic [ID_WIDTH-1:0]            flt_id,
  input  logic [ID_WIDTH-1:0]            flt_mask,
  output logic [$clog2(DEPTH):0]         count,
  output logic [7:0]                     ovf_cnt,
  input  logic                           ovf_clr,
  output logic                           irq
);
  localparam int HIT_W = $clog2(NUM_FILTERS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic                flt_en_q   [NUM_FILTERS];
  logic                flt_en_d   [NUM_FILTERS];
  logic [ID_WIDTH-1:0] flt_id_q   [NUM_FILTERS];
  logic [ID_WIDTH-1:0] flt_id_d   [NUM_FILTERS];
  logic [ID_WIDTH-1:0] flt_mask_q [NUM_FILTERS];
  logic [ID_WIDTH-1:0] flt_mask_d [NUM_FILTERS];

  logic [ID_WIDTH-1:0] mem_id_q   [DEPTH];
  logic [3:0]          mem_dlc_q  [DEPTH];
  logic [63:0]         mem_data_q [DEPTH];
  logic [HIT_W-1:0]    mem_hit_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       ovf_cnt_q, ovf_cnt_d;
  logic             rd_valid_q, rd_valid_d;

  logic             any_en_s, found_s, match_s, accept_s;
  logic [HIT_W-1:0] hit_s;
  logic             full_s, pop_s, push_s, ovf_s;

  // Acceptance: scan from the top so the lowest matching index is the last writer.
  always_comb begin
    any_en_s = 1'b0;
    found_s  = 1'b0;
    match_s  = 1'b0;
    hit_s    = '0;
    for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
      match_s  = flt_en_q[k] && (((bus.frm_id ^ flt_id_q[k]) & flt_mask_q[k]) == '0);
      hit_s    = match_s ? HIT_W'(k) : hit_s;
      found_s  = found_s | match_s;
      any_en_s = any_en_s | flt_en_q[k];
    end
    accept_s = bus.frm_valid & (~any_en_s | found_s);
  end

  // Filter table next-state.
  always_comb begin
    flt_en_d   = flt_en_q;
    flt_id_d   = flt_id_q;
    flt_mask_d = flt_mask_q;
    if (flt_we && (int'(flt_idx) < NUM_FILTERS)) begin
      flt_en_d[flt_idx]   = flt_en;
      flt_id_d[flt_idx]   = flt_id;
      flt_mask_d[flt_idx] = flt_mask;
    end else begin
      flt_en_d = flt_en_q;
    end
  end

  // FIFO control: a pop frees the slot a full-FIFO push needs in the same cycle.
  always_comb begin
    full_s     = (count_q == DEPTH_C);
    pop_s      = bus.rd_pop & rd_valid_q;
    push_s     = accept_s & (~full_s | pop_s);
    ovf_s      = accept_s & full_s & ~pop_s;
    wr_ptr_d   = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d   = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    rd_valid_d = (count_d != '0);
    if (ovf_clr) begin
      ovf_cnt_d = {7'd0, ovf_s};
    end else if (ovf_s && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Control and filter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_cnt_q  <= 8'd0;
      rd_valid_q <= 1'b0;
      for (int k = 0; k < NUM_FILTERS; k++) begin
        flt_en_q[k]   <= 1'b0;
        flt_id_q[k]   <= '0;
        flt_mask_q[k] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_cnt_q  <= ovf_cnt_d;
      rd_valid_q <= rd_valid_d;
      flt_en_q   <= flt_en_d;
      flt_id_q   <= flt_id_d;
      flt_mask_q <= flt_mask_d;
    end
  end

  // Frame storage, deliberately without reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_id_q[wr_ptr_q]   <= bus.frm_id;
      mem_dlc_q[wr_ptr_q]  <= bus.frm_dlc;
      mem_data_q[wr_ptr_q] <= bus.frm_data;
      mem_hit_q[wr_ptr_q]  <= hit_s;
    end
  end

`ifdef QAR_CAN_RX_TIMESTAMP_EN
  logic [15:0] tstamp_q, tstamp_d;
  logic [15:0] mem_ts_q [DEPTH];

  assign tstamp_d = tstamp_q + 16'd1;

  // Free-running capture timebase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tstamp_q <= 16'd0;
    end else begin
      tstamp_q <= tstamp_d;
    end
  end

  // Timestamp storage alongside the frame entries.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_ts_q[wr_ptr_q] <= tstamp_q;
    end
  end

  assign bus.rd_tstamp = rd_valid_q ? mem_ts_q[rd_ptr_q] : 16'd0;
`else
  assign bus.rd_tstamp = 16'd0;
`endif

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_id    = rd_valid_q ? mem_id_q[rd_ptr_q]   : '0;
  assign bus.rd_dlc   = rd_valid_q ? mem_dlc_q[rd_ptr_q]  : 4'd0;
  assign bus.rd_data  = rd_valid_q ? mem_data_q[rd_ptr_q] : 64'd0;
  assign bus.rd_hit   = rd_valid_q ? mem_hit_q[rd_ptr_q]  : '0;
  assign count        = count_q;
  assign ovf_cnt      = ovf_cnt_q;
  assign irq          = rd_valid_q;
endmodule

// File: tb/tb_qar_can_rx_mailbox.sv
// Scoreboard bench for qar_can_rx_mailbox: directed frames push expectations,
// a negedge monitor checks every popped head entry.
module tb_qar_can_rx_mailbox;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flt_we;
  logic [0:0]  flt_idx;
  logic        flt_en;
  logic [10:0] flt_id;
  logic [10:0] flt_mask;
  logic [2:0]  count;
  logic [7:0]  ovf_cnt;
  logic        ovf_clr;
  logic        irq;

  typedef struct packed {
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic        hit;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  qar_can_rx_mailbox_if #(.ID_WIDTH(11), .NUM_FILTERS(2)) bus ();

  qar_can_rx_mailbox #(.DEPTH(4), .NUM_FILTERS(2), .ID_WIDTH(11)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .flt_we   (flt_we),
    .flt_idx  (flt_idx),
    .flt_en   (flt_en),
    .flt_id   (flt_id),
    .flt_mask (flt_mask),
    .count    (count),
    .ovf_cnt  (ovf_cnt),
    .ovf_clr  (ovf_clr),
    .irq      (irq)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data,
                      input bit store, input logic hit);
    bus.frm_valid = 1'b1;
    bus.frm_id    = id;
    bus.frm_dlc   = dlc;
    bus.frm_data  = data;
    if (store) exp_q.push_back('{id: id, dlc: dlc, data: data, hit: hit});
    step();
    bus.frm_valid = 1'b0;
  endtask

  task automatic pop1();
    bus.rd_pop = 1'b1;
    step();
    bus.rd_pop = 1'b0;
  endtask

  task automatic wr_flt(input logic idx, input logic en, input logic [10:0] id, input logic [10:0] mask);
    flt_we   = 1'b1;
    flt_idx  = idx;
    flt_en   = en;
    flt_id   = id;
    flt_mask = mask;
    step();
    flt_we = 1'b0;
  endtask

  // Monitor: compare each consumed head entry, and check blanked head while empty.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rd_valid === 1'b1 && bus.rd_pop === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pop: got id %0h, expected no entry", bus.rd_id);
        end else begin
          e = exp_q.pop_front();
          chk("head_id",   64'(bus.rd_id),   64'(e.id));
          chk("head_dlc",  64'(bus.rd_dlc),  64'(e.dlc));
          chk("head_data", bus.rd_data,      e.data);
          chk("head_hit",  64'(bus.rd_hit),  64'(e.hit));
`ifndef QAR_CAN_RX_TIMESTAMP_EN
          chk("tstamp_tied", 64'(bus.rd_tstamp), 64'd0);
`endif
        end
      end else if (bus.rd_valid === 1'b0) begin
        chk("empty_fields", 64'({bus.rd_id, bus.rd_dlc, bus.rd_hit, bus.rd_tstamp}), 64'd0);
        chk("empty_data", bus.rd_data, 64'd0);
      end
    end
  end

  initial begin
    logic [15:0] t0;
    bus.frm_valid = 1'b0; bus.frm_id = '0; bus.frm_dlc = 4'd0; bus.frm_data = 64'd0;
    bus.rd_pop = 1'b0;
    flt_we = 1'b0; flt_idx = 1'b0; flt_en = 1'b0; flt_id = '0; flt_mask = '0;
    ovf_clr = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_count",    64'(count),        64'd0);
    chk("rst_ovf",      64'(ovf_cnt),      64'd0);
    chk("rst_irq",      64'(irq),          64'd0);

    // Promiscuous: two frames, drained in order.
    send(11'h123, 4'd4, 64'h00000000_DEADBEEF, 1'b1, 1'b0);
    chk("push_latency_valid", 64'(bus.rd_valid), 64'd1);
    chk("push_latency_id",    64'(bus.rd_id),    64'h123);
    send(11'h321, 4'd8, 64'h01020304_CAFEBABE, 1'b1, 1'b0);
    chk("count_2", 64'(count), 64'd2);
    pop1();
    chk("count_1", 64'(count), 64'd1);
    chk("irq_held", 64'(irq), 64'd1);
    pop1();
    chk("count_0", 64'(count), 64'd0);
    chk("irq_drop", 64'(irq), 64'd0);

    // Filter 1 only: 0x123 rejected silently, 0x321 accepted with hit 1.
    wr_flt(1'b1, 1'b1, 11'h320, 11'h7F0);
    send(11'h123, 4'd1, 64'h11, 1'b0, 1'b0);
    send(11'h321, 4'd2, 64'h22, 1'b1, 1'b1);
    chk("flt_count", 64'(count), 64'd1);
    chk("flt_ovf",   64'(ovf_cnt), 64'd0);
    pop1();

    // Both filters match: lowest index wins.
    wr_flt(1'b0, 1'b1, 11'h321, 11'h7FF);
    send(11'h321, 4'd3, 64'h33, 1'b1, 1'b0);
    pop1();

    // Filter write coinciding with a frame uses the old filter values.
    flt_we = 1'b1; flt_idx = 1'b0; flt_en = 1'b1; flt_id = 11'h123; flt_mask = 11'h7FF;
    bus.frm_valid = 1'b1; bus.frm_id = 11'h123; bus.frm_dlc = 4'd5; bus.frm_data = 64'h44;
    step();
    flt_we = 1'b0; bus.frm_valid = 1'b0;
    chk("flt_same_cycle_old", 64'(count), 64'd0);
    send(11'h123, 4'd6, 64'h55, 1'b1, 1'b0);
    chk("flt_next_cycle_new", 64'(count), 64'd1);
    pop1();

    // Overflow: six frames into depth four, then push+pop while full.
    wr_flt(1'b0, 1'b0, 11'h000, 11'h000);
    wr_flt(1'b1, 1'b0, 11'h000, 11'h000);
    for (int i = 1; i <= 6; i++)
      send(11'(16 + i), 4'(i + 9), {32'(i), 32'hA5A5_0000 + 32'(i)}, (i <= 4), 1'b0);
    chk("full_count", 64'(count),   64'd4);
    chk("full_ovf",   64'(ovf_cnt), 64'd2);
    bus.rd_pop = 1'b1;
    send(11'h07F, 4'd7, 64'h7777_7777_7777_7777, 1'b1, 1'b0);
    bus.rd_pop = 1'b0;
    chk("full_pushpop_count", 64'(count),   64'd4);
    chk("full_pushpop_ovf",   64'(ovf_cnt), 64'd2);
    repeat (4) pop1();
    chk("drain_count", 64'(count), 64'd0);

    // Saturation and clear behaviour.
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clr_0", 64'(ovf_cnt), 64'd0);
    for (int i = 0; i < 4; i++) send(11'(11'h200 + i), 4'd1, 64'(i), 1'b1, 1'b0);
    bus.frm_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      bus.frm_id = 11'(11'h300 + i);
      step();
    end
    bus.frm_valid = 1'b0;
    chk("ovf_sat", 64'(ovf_cnt), 64'd255);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clr_after_sat", 64'(ovf_cnt), 64'd0);
    ovf_clr = 1'b1;
    send(11'h0AA, 4'd1, 64'hAA, 1'b0, 1'b0);
    ovf_clr = 1'b0;
    chk("ovf_clr_with_ovf", 64'(ovf_cnt), 64'd1);
    repeat (4) pop1();

    // Push and pop together while empty: push only.
    bus.rd_pop = 1'b1;
    send(11'h0BB, 4'd2, 64'hBB, 1'b1, 1'b0);
    bus.rd_pop = 1'b0;
    chk("empty_pushpop_count", 64'(count), 64'd1);
    pop1();

`ifdef QAR_CAN_RX_TIMESTAMP_EN
    send(11'h0C1, 4'd1, 64'hC1, 1'b1, 1'b0);
    repeat (9) step();
    send(11'h0C2, 4'd1, 64'hC2, 1'b1, 1'b0);
    t0 = bus.rd_tstamp;
    pop1();
    chk("tstamp_delta", 64'(16'(bus.rd_tstamp - t0)), 64'd10);
    pop1();
`else
    t0 = 16'd0;
`endif

    // Asynchronous reset with frames stored and a filter programmed.
    wr_flt(1'b0, 1'b1, 11'h555, 11'h7FF);
    for (int i = 0; i < 3; i++) send(11'(11'h555), 4'(i), 64'(i), 1'b1, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.rd_valid), 64'd0);
    chk("async_rst_count", 64'(count),        64'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    send(11'h123, 4'd9, 64'h99, 1'b1, 1'b0);
    chk("post_rst_flt_cleared", 64'(count), 64'd1);
    pop1();

    step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
